// File: rtl/ps2_rx_deframer.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame deserializer, E0/F0 folding.
// Code/flags register one mclk after the stop-bit fall; a code completing while one is held unread is dropped (rx_overrun).
module ps2_rx_deframer #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int TIMEOUT_WD     = 16
) (
  input  logic       mclk,
  input  logic       puc_rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       rx_read,
  output logic [7:0] rx_code,
  output logic       rx_extended,
  output logic       rx_released,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_f, clk_f_d;
  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par_bit;
  logic [TIMEOUT_WD-1:0] tmo_cnt;
  logic                  ext_pend, rel_pend;

  logic fall, stop_fall, frame_good, is_prefix, tmo_hit, code_done, err_set;

  always_comb begin
    fall       = clk_f_d & ~clk_f;
    stop_fall  = fall && (state == STOP);
    frame_good = dat_s2 & (^{shreg, par_bit});
    is_prefix  = (shreg == 8'hE0) || (shreg == 8'hF0);
    tmo_hit    = (state != IDLE) && !fall &&
                 (tmo_cnt == TIMEOUT_WD'(TIMEOUT_CYCLES - 1));
    code_done  = stop_fall & frame_good & ~is_prefix;
    err_set    = (stop_fall & ~frame_good) | tmo_hit;
  end

  assign busy = (state != IDLE);

  // Idle level of both PS/2 lines is high, so conditioning resets to 1.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_hist <= '1;
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      dat_s1   <= ps2_data_i;
      dat_s2   <= dat_s1;
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s2};
      if (clk_hist == '0)
        clk_f <= 1'b0;
      else if (&clk_hist)
        clk_f <= 1'b1;
      clk_f_d  <= clk_f;
    end
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tmo_cnt     <= '0;
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
      rx_code     <= '0;
      rx_extended <= 1'b0;
      rx_released <= 1'b0;
      rx_valid    <= 1'b0;
      rx_error    <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (fall || state == IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TIMEOUT_WD'(1);

      case (state)
        IDLE: if (fall && !dat_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: if (fall) begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= PARITY;
        end
        PARITY: if (fall) begin
          par_bit <= dat_s2;
          state   <= STOP;
        end
        STOP: if (fall)
          state <= IDLE;
        default: state <= IDLE;
      endcase
      if (tmo_hit)
        state <= IDLE;

      if (err_set) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (stop_fall) begin
        if (shreg == 8'hE0)
          ext_pend <= 1'b1;
        else if (shreg == 8'hF0)
          rel_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end

      // A read in the completion cycle frees the slot, so the new code loads.
      if (code_done && (!rx_valid || rx_read)) begin
        rx_valid    <= 1'b1;
        rx_code     <= shreg;
        rx_extended <= ext_pend;
        rx_released <= rel_pend;
      end else if (rx_valid && rx_read) begin
        rx_valid <= 1'b0;
      end

      rx_error   <= err_set | (rx_error & ~rx_read);
      rx_overrun <= (code_done & rx_valid & ~rx_read) | (rx_overrun & ~rx_read);
    end
  end

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Directed bench for ps2_rx_deframer: frames, prefixes, errors, timeout, overrun, glitch, reset.
module tb_ps2_rx_deframer;
  localparam int HALF = 20;
  localparam int TMO  = 300;

  logic       mclk = 1'b0;
  logic       puc_rst_n = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_code;
  logic       rx_extended, rx_released, rx_valid, rx_error, rx_overrun, busy;
  logic [12:0] outs;

  int   n_checks = 0;
  int   n_fail = 0;
  int   last_lat = 8;
  int   lat_meas = 8;
  logic valid_at_idle = 1'b0;

  assign outs = {rx_code, rx_extended, rx_released, rx_valid, rx_error, rx_overrun, busy};

  ps2_rx_deframer #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WD(9)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rx_read(rx_read), .rx_code(rx_code), .rx_extended(rx_extended),
    .rx_released(rx_released), .rx_valid(rx_valid), .rx_error(rx_error),
    .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_i = b;
    tick(HALF);
    ps2_clk_i = 1'b0;
    tick(HALF);
    ps2_clk_i = 1'b1;
  endtask

  task automatic read_pulse();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
    tick(1);
  endtask

  // read_at < 0: no read; otherwise rx_read is high between edges read_at and read_at+1
  // counted from the stop-bit clock fall.
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int read_at);
    logic par;
    int   k;
    bit   done;
    par = (~^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_data_i = 1'b1;
    tick(HALF);
    ps2_clk_i = 1'b0;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      rx_read = (k == read_at);
      tick(1);
      k++;
      if (!busy) done = 1'b1;
    end
    rx_read = 1'b0;
    if (!done) check("stop_fall_seen", busy, 0);
    last_lat = k;
    valid_at_idle = rx_valid;
    if (HALF - k > 0) tick(HALF - k);
    ps2_clk_i = 1'b1;
    tick(HALF);
  endtask

  initial begin
    int w;
    tick(3);
    check("reset_outs", outs, 0);
    puc_rst_n = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, -1);
    lat_meas = last_lat;
    check("1c_valid_at_idle", valid_at_idle, 1);
    check("1c_code", rx_code, 8'h1C);
    check("1c_flags_err", {rx_extended, rx_released, rx_error}, 0);
    read_pulse();
    check("1c_read_clears", rx_valid, 0);

    send_frame(8'hE0, 1'b0, -1);
    check("e0_no_valid", rx_valid, 0);
    send_frame(8'hF0, 1'b0, -1);
    check("f0_no_valid", rx_valid, 0);
    send_frame(8'h74, 1'b0, -1);
    check("74_valid", rx_valid, 1);
    check("74_code", rx_code, 8'h74);
    check("74_flags", {rx_extended, rx_released}, 2'b11);
    read_pulse();
    send_frame(8'h74, 1'b0, -1);
    check("74b_code", rx_code, 8'h74);
    check("74b_flags", {rx_extended, rx_released}, 2'b00);
    read_pulse();

    send_frame(8'h1C, 1'b1, -1);
    check("badpar_valid", rx_valid, 0);
    check("badpar_error", rx_error, 1);
    check("badpar_busy", busy, 0);
    send_frame(8'h2A, 1'b0, -1);
    check("2a_valid", rx_valid, 1);
    check("2a_code", rx_code, 8'h2A);
    check("2a_error_sticky", rx_error, 1);
    read_pulse();
    check("2a_read_clr_err", rx_error, 0);
    check("2a_read_clr_vld", rx_valid, 0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    tick(TMO / 2);
    check("tmo_still_busy", busy, 1);
    w = 0;
    while (busy && w < TMO) begin
      tick(1);
      w++;
    end
    check("tmo_busy", busy, 0);
    check("tmo_error", rx_error, 1);
    check("tmo_no_valid", rx_valid, 0);
    read_pulse();
    check("tmo_err_cleared", rx_error, 0);
    send_frame(8'h15, 1'b0, -1);
    check("15_valid", rx_valid, 1);
    check("15_code", rx_code, 8'h15);
    check("15_flags", {rx_extended, rx_released}, 2'b00);
    read_pulse();

    send_frame(8'h1C, 1'b0, -1);
    send_frame(8'h32, 1'b0, -1);
    check("ovr_code_held", rx_code, 8'h1C);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", rx_overrun, 1);
    read_pulse();
    check("ovr_read_vld", rx_valid, 0);
    check("ovr_read_flag", rx_overrun, 0);

    send_frame(8'h1C, 1'b0, -1);
    send_frame(8'hE0, 1'b0, -1);
    check("prefix_no_ovr", rx_overrun, 0);
    check("prefix_code_held", rx_code, 8'h1C);
    send_frame(8'h32, 1'b0, lat_meas - 1);
    check("coinc_code", rx_code, 8'h32);
    check("coinc_valid", rx_valid, 1);
    check("coinc_no_ovr", rx_overrun, 0);
    check("coinc_ext", {rx_extended, rx_released}, 2'b10);
    read_pulse();

    ps2_data_i = 1'b0;
    tick(5);
    ps2_clk_i = 1'b0;
    tick(3);
    ps2_clk_i = 1'b1;
    tick(20);
    check("glitch_no_start", busy, 0);
    ps2_data_i = 1'b1;
    send_frame(8'h5A, 1'b0, -1);
    check("5a_code", rx_code, 8'h5A);
    check("5a_err", rx_error, 0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    check("midframe_busy", busy, 1);
    puc_rst_n = 1'b0;
    tick(2);
    check("midframe_reset_outs", outs, 0);
    puc_rst_n = 1'b1;
    ps2_data_i = 1'b1;
    tick(HALF);
    send_frame(8'h4D, 1'b0, -1);
    check("4d_valid", rx_valid, 1);
    check("4d_code", rx_code, 8'h4D);
    check("4d_status", {rx_extended, rx_released, rx_error, rx_overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
